// File: rtl/vec_stream_pkg.sv
// Shared types and defaults for the vector-datapath stream blocks.
package vec_stream_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } demux_state_e;

  typedef logic dest_t;

endpackage

// File: rtl/stream_pipe_slot.sv
// One-entry valid/ready register carrying data, last and a destination tag.
module stream_pipe_slot
  import vec_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  dest_t             in_dest,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output dest_t             out_dest,
  output logic              out_valid,
  input  logic              out_ready
);

  logic              full_q, full_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  dest_t             dest_q, dest_d;
  logic              drain;
  logic              acc;

  // A drain in the same cycle frees the slot for a new beat, keeping 1 beat/cycle.
  always_comb begin
    drain    = full_q & out_ready;
    in_ready = !full_q | drain;
    acc      = in_valid & in_ready;
    full_d   = full_q;
    data_d   = data_q;
    last_d   = last_q;
    dest_d   = dest_q;
    if (acc) begin
      full_d = 1'b1;
      data_d = in_data;
      last_d = in_last;
      dest_d = in_dest;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
      dest_q <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      last_q <= last_d;
      dest_q <= dest_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_dest  = dest_q;

endmodule

// File: rtl/stream_demux_1_2.sv
// Packet-locked 1-to-2 stream steering unit; DEMUX_STATS_EN adds per-destination beat counters.
module stream_demux_1_2
  import vec_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
`ifdef DEMUX_STATS_EN
  ,
  parameter int unsigned CNT_W  = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic              in_last,
  output logic [DATA_W-1:0] out0_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic              out0_last,
  output logic [DATA_W-1:0] out1_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic              out1_last
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
`endif
);

  demux_state_e      state_q, state_d;
  dest_t             lock_dest_q, lock_dest_d;
  dest_t             eff_dest;
  logic              acc_in;
  logic              slot_valid;
  logic              slot_last;
  dest_t             slot_dest;
  logic [DATA_W-1:0] slot_data;
  logic              sel_ready;
  logic              drain;

  assign sel_ready = (slot_dest == 1'b1) ? out1_ready : out0_ready;
  assign drain     = slot_valid & sel_ready;
  assign acc_in    = in_valid & in_ready;

  stream_pipe_slot #(.DATA_W(DATA_W)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_dest   (eff_dest),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (slot_data),
    .out_last  (slot_last),
    .out_dest  (slot_dest),
    .out_valid (slot_valid),
    .out_ready (sel_ready)
  );

  // Destination is taken from in_sel on the first beat and held until the last beat.
  always_comb begin
    state_d     = state_q;
    lock_dest_d = lock_dest_q;
    eff_dest    = in_sel;
    case (state_q)
      IDLE: begin
        eff_dest = in_sel;
        if (acc_in && !in_last) begin
          lock_dest_d = in_sel;
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        eff_dest = lock_dest_q;
        if (acc_in && in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_dest_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_dest_q <= lock_dest_d;
    end
  end

  assign out0_valid = slot_valid & (slot_dest == 1'b0);
  assign out1_valid = slot_valid & (slot_dest == 1'b1);
  assign out0_data  = slot_data;
  assign out1_data  = slot_data;
  assign out0_last  = slot_last;
  assign out1_last  = slot_last;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Counters wrap naturally at 2^CNT_W.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (drain && (slot_dest == 1'b0)) cnt0_d = cnt0_q + CNT_W'(1);
    if (drain && (slot_dest == 1'b1)) cnt1_d = cnt1_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_stream_demux_1_2.sv
// Scoreboard bench for stream_demux_1_2; counter checks enabled with DEMUX_STATS_EN.
module tb_stream_demux_1_2;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic        in_last;
  logic [31:0] out0_data;
  logic        out0_valid;
  logic        out0_ready;
  logic        out0_last;
  logic [31:0] out1_data;
  logic        out1_valid;
  logic        out1_ready;
  logic        out1_last;
`ifdef DEMUX_STATS_EN
  logic [15:0] cnt0;
  logic [15:0] cnt1;
`endif

  stream_demux_1_2 dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_last  (out0_last),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_last  (out1_last)
`ifdef DEMUX_STATS_EN
    ,
    .cnt0       (cnt0),
    .cnt1       (cnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        port;
    logic        last;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        hold [0:1];
  logic [31:0] held_d [0:1];
  logic        held_l [0:1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pops and compares one expected beat per output handshake; also checks hold stability.
  task automatic mon_port(input int p, input logic v, input logic r,
                          input logic [31:0] d, input logic l);
    exp_t e;
    if (hold[p]) begin
      chk($sformatf("hold_valid%0d", p), 64'(v), 64'(1));
      chk($sformatf("hold_data%0d", p), {31'd0, l, d}, {31'd0, held_l[p], held_d[p]});
    end
    if (v && r) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat%0d: got %0h expected none", p, d);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("port_of_%0h", e.data), 64'(p), 64'(e.port));
        chk($sformatf("data%0d", p), 64'(d), 64'(e.data));
        chk($sformatf("last%0d_of_%0h", p, e.data), 64'(l), 64'(e.last));
      end
    end
    hold[p]   = v && !r;
    held_d[p] = d;
    held_l[p] = l;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold[0] = 1'b0;
      hold[1] = 1'b0;
    end else begin
      if (out0_valid && out1_valid) begin
        checks++;
        errors++;
        $display("FAIL both_valid: got 1 expected 0");
      end
      mon_port(0, out0_valid, out0_ready, out0_data, out0_last);
      mon_port(1, out1_valid, out1_ready, out1_data, out1_last);
    end
  end

  // Presents one beat; pushes its expected result when the handshake is seen.
  task automatic send(input logic [31:0] d, input logic sel, input logic last,
                      input logic ep, output int stall);
    stall    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = sel;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stall++;
      if (stall >= 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no in_ready expected accept of %0h", d);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back({ep, last, d});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_last  = 1'b0;
  endtask

  int st;
  int total_stall;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    hold[0]    = 1'b0;
    hold[1]    = 1'b0;
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_data    = 32'hA5A5_A5A5;
    in_sel     = 1'b0;
    in_last    = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;

    // Reset held 3 cycles with in_valid asserted
    @(posedge clk);
    @(negedge clk);
    chk("rst_out0_valid", 64'(out0_valid), 64'(0));
    chk("rst_out1_valid", 64'(out1_valid), 64'(0));
    chk("rst_out0_data", 64'(out0_data), 64'(0));
    chk("rst_out1_data", 64'(out1_data), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    chk("post_rst_valids", {62'd0, out1_valid, out0_valid}, 64'(0));

    // Single-beat packet to destination 1
    @(posedge clk);
    #1;
    send(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, st);
    idle();
    @(negedge clk);
    chk("single_out1_valid", 64'(out1_valid), 64'(1));
    chk("single_out1_data", 64'(out1_data), 64'(32'hDEAD_BEEF));
    chk("single_out1_last", 64'(out1_last), 64'(1));
    chk("single_out0_valid", 64'(out0_valid), 64'(0));
    @(posedge clk);
    #1;

    // Destination locks for the whole packet despite in_sel toggling
    send(32'h1, 1'b0, 1'b0, 1'b0, st);
    send(32'h2, 1'b1, 1'b0, 1'b0, st);
    send(32'h3, 1'b1, 1'b0, 1'b0, st);
    send(32'h4, 1'b1, 1'b1, 1'b0, st);
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Backpressure on destination 0 while destination 1 is ready
    out0_ready = 1'b0;
    send(32'hB000_0001, 1'b0, 1'b0, 1'b0, st);
    idle();
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    chk("bp_out0_valid", 64'(out0_valid), 64'(1));
    chk("bp_out0_data", 64'(out0_data), 64'(32'hB000_0001));
    @(posedge clk);
    #1;
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        out0_ready = 1'b1;
      end
    join_none
    send(32'hB000_0002, 1'b1, 1'b0, 1'b0, st);
    chk("bp_stalled", 64'(st >= 2), 64'(1));
    send(32'hB000_0003, 1'b1, 1'b1, 1'b0, st);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Alternating single-beat packets at full rate, from a fresh reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total_stall = 0;
    for (int i = 0; i < 100; i++) begin
      send(32'h1000 + 32'(i), 1'(i % 2), 1'b1, 1'(i % 2), st);
      total_stall += st;
    end
    idle();
    chk("throughput_stalls", 64'(total_stall), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef DEMUX_STATS_EN
    chk("cnt0", 64'(cnt0), 64'(50));
    chk("cnt1", 64'(cnt1), 64'(50));
`endif
    @(posedge clk);
    #1;

    // Reset after beat 2 of a 4-beat packet to destination 1
    send(32'hC000_0001, 1'b1, 1'b0, 1'b1, st);
    send(32'hC000_0002, 1'b1, 1'b0, 1'b1, st);
    idle();
    rst        = 1'b1;
    out1_ready = 1'b0;
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    out1_ready = 1'b1;
    @(negedge clk);
    chk("midrst_valids", {62'd0, out1_valid, out0_valid}, 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    send(32'hD000_0001, 1'b0, 1'b0, 1'b0, st);
    send(32'hD000_0002, 1'b1, 1'b1, 1'b0, st);
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
